// File: rtl/servo_ramp_scheduler_pkg.sv
// Shared definitions for the servo ramp scheduler slice.
//   N_CH / CH_W / VAL_W : channel count, channel index width, channel value width
//   sched_state_t       : scheduler FSM states (IDLE, SWEEP)
//   wr_port_t           : register-file write port bundle {en, addr, data}
//   clamp_val()         : saturate a value into [lo, hi]; used only when the
//                         SERVO_RAMP_CLAMP_EN build macro is defined
package servo_pkg;

    localparam int N_CH  = 64;
    localparam int CH_W  = 6;
    localparam int VAL_W = 11;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic             en;
        logic [CH_W-1:0]  addr;
        logic [VAL_W-1:0] data;
    } wr_port_t;

    function automatic logic [VAL_W-1:0] clamp_val(
        input logic [VAL_W-1:0] v,
        input logic [VAL_W-1:0] lo,
        input logic [VAL_W-1:0] hi
    );
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/servo_ramp_scheduler_sweep_tick_gen.sv
// Free-running sweep period generator.
//   clk, rst : clock and asynchronous active-high reset
//   tick     : high for one cycle each time the counter wraps from
//              TICK_DIV-1 back to 0 (once every TICK_DIV cycles)
module sweep_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_ramp_scheduler.sv
// Servo ramp scheduler: owns per-channel target/current values and funnels
// every register-file write through one port. Host writes (one-entry pending
// slot) always win over the periodic ramp sweep, which slews each channel's
// current value toward its target by at most STEP per sweep.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   host_valid/host_ready         host request handshake (ready = slot empty)
//   host_addr/host_data/host_imm  channel, value, 1 = jump now / 0 = new target
//   wr_en/wr_addr/wr_data         register-file write port, one cycle per write
//   busy                          sweep in progress
//   sweep_done                    one-cycle pulse after the last channel step
//   tick_overrun                  sticky: a tick arrived while still sweeping
// Build option: define SERVO_RAMP_CLAMP_EN to clamp host_data to
// [VAL_MIN, VAL_MAX] before it is stored or written.
module servo_ramp_scheduler
    import servo_pkg::*;
#(
    parameter int STEP     = 8,
    parameter int TICK_DIV = 50000,
    parameter int VAL_MIN  = 0,
    parameter int VAL_MAX  = 2047
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [CH_W-1:0]  host_addr,
    input  logic [VAL_W-1:0] host_data,
    input  logic             host_imm,
    output logic             wr_en,
    output logic [CH_W-1:0]  wr_addr,
    output logic [VAL_W-1:0] wr_data,
    output logic             busy,
    output logic             sweep_done,
    output logic             tick_overrun
);

    localparam logic [CH_W-1:0]     LAST_IDX = CH_W'(N_CH - 1);
    localparam logic [VAL_W-1:0]    STEP_V   = VAL_W'(STEP);
    localparam logic signed [VAL_W:0] STEP_S = (VAL_W + 1)'(STEP);

    sched_state_t     state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_imm_q, pend_imm_d;
    logic [CH_W-1:0]  pend_addr_q, pend_addr_d;
    logic [VAL_W-1:0] pend_data_q, pend_data_d;
    wr_port_t         wr_q, wr_d;
    logic             sweep_done_q, sweep_done_d;
    logic             overrun_q, overrun_d;

    logic [VAL_W-1:0] target_q  [N_CH];
    logic [VAL_W-1:0] current_q [N_CH];

    // At most one target and one current update per cycle.
    logic             tgt_we, cur_we;
    logic [CH_W-1:0]  tgt_wa, cur_wa;
    logic [VAL_W-1:0] tgt_wd, cur_wd;

    logic             tick;
    logic             sweep_step;
    logic [VAL_W-1:0] host_val;
    logic [VAL_W-1:0] cur_val, tgt_val, step_val;
    logic signed [VAL_W:0] diff;

    sweep_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

`ifdef SERVO_RAMP_CLAMP_EN
    assign host_val = clamp_val(host_data, VAL_W'(VAL_MIN), VAL_W'(VAL_MAX));
`else
    assign host_val = host_data;
    // Bounds carry no meaning without clamping; fold them into a dead signal.
    logic unused_bounds;
    assign unused_bounds = (VAL_MIN > VAL_MAX);
`endif

    // A sweep step only happens on cycles the host slot does not claim.
    assign sweep_step = (state_q == SWEEP) && !pend_valid_q;

    // Step toward target; the extra sign bit keeps the difference exact, so
    // the step can never wrap or overshoot.
    always_comb begin
        cur_val = current_q[idx_q];
        tgt_val = target_q[idx_q];
        diff    = $signed({1'b0, tgt_val}) - $signed({1'b0, cur_val});
        if (diff > STEP_S) begin
            step_val = cur_val + STEP_V;
        end else if (diff < -STEP_S) begin
            step_val = cur_val - STEP_V;
        end else begin
            step_val = tgt_val;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = SWEEP;
            SWEEP:   if (sweep_step && idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy         = (state_q == SWEEP);
        host_ready   = !pend_valid_q;
        wr_en        = wr_q.en;
        wr_addr      = wr_q.addr;
        wr_data      = wr_q.data;
        sweep_done   = sweep_done_q;
        tick_overrun = overrun_q;
    end

    // Datapath: host service, sweep step, index and pending slot.
    always_comb begin
        idx_d        = idx_q;
        pend_valid_d = pend_valid_q;
        pend_imm_d   = pend_imm_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        wr_d         = '0;
        sweep_done_d = 1'b0;
        overrun_d    = overrun_q | (tick && state_q == SWEEP);
        tgt_we       = 1'b0;
        tgt_wa       = pend_addr_q;
        tgt_wd       = pend_data_q;
        cur_we       = 1'b0;
        cur_wa       = pend_addr_q;
        cur_wd       = pend_data_q;

        if (pend_valid_q) begin
            pend_valid_d = 1'b0;
            tgt_we       = 1'b1;
            if (pend_imm_q) begin
                cur_we = 1'b1;
                wr_d   = '{en: 1'b1, addr: pend_addr_q, data: pend_data_q};
            end
        end else if (state_q == SWEEP) begin
            if (diff != '0) begin
                cur_we = 1'b1;
                cur_wa = idx_q;
                cur_wd = step_val;
                wr_d   = '{en: 1'b1, addr: idx_q, data: step_val};
            end
            if (idx_q == LAST_IDX) begin
                sweep_done_d = 1'b1;
            end
            idx_d = idx_q + CH_W'(1);
        end

        if (state_q == IDLE && tick) begin
            idx_d = '0;
        end

        // Slot is empty whenever host_ready is high, so accept never collides
        // with service.
        if (host_valid && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_imm_d   = host_imm;
            pend_addr_d  = host_addr;
            pend_data_d  = host_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_imm_q   <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            wr_q         <= '0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                target_q[i]  <= '0;
                current_q[i] <= '0;
            end
        end else begin
            idx_q        <= idx_d;
            pend_valid_q <= pend_valid_d;
            pend_imm_q   <= pend_imm_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            wr_q         <= wr_d;
            sweep_done_q <= sweep_done_d;
            overrun_q    <= overrun_d;
            if (tgt_we) target_q[tgt_wa]  <= tgt_wd;
            if (cur_we) current_q[cur_wa] <= cur_wd;
        end
    end

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for servo_ramp_scheduler. A behavioural model advances one
// step per clock edge from the channel rules (targets, currents, a sweep
// pointer, a pending request) and queues the expected write and status for
// that edge; an independent monitor pops and compares on the falling edge.
module tb_servo_ramp_scheduler;
    import servo_pkg::*;

    localparam int STEP     = 8;
    localparam int TICK_DIV = 100;
    localparam int VAL_MIN  = 0;
    localparam int VAL_MAX  = 1800;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             host_valid, host_ready, host_imm;
    logic [CH_W-1:0]  host_addr;
    logic [VAL_W-1:0] host_data;
    logic             wr_en;
    logic [CH_W-1:0]  wr_addr;
    logic [VAL_W-1:0] wr_data;
    logic             busy, sweep_done, tick_overrun;

    servo_ramp_scheduler #(
        .STEP(STEP), .TICK_DIV(TICK_DIV), .VAL_MIN(VAL_MIN), .VAL_MAX(VAL_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data), .host_imm(host_imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .sweep_done(sweep_done), .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int addr; int data; bit imm; } req_t;
    typedef struct { int cyc; int addr; int data; } wr_exp_t;
    typedef struct { int cyc; bit busy; bit done; bit ovr; } st_exp_t;

    req_t    req_q[$];
    wr_exp_t exp_q[$];
    st_exp_t st_q[$];
    bit      mon_en = 1'b0;

    // Reference model state
    int   m_tgt [N_CH];
    int   m_cur [N_CH];
    bit   m_pend;
    req_t m_pend_req;
    bit   m_sweep;
    int   m_idx;
    int   m_cnt;
    bit   m_ovr;

    function automatic int host_value(int d);
`ifdef SERVO_RAMP_CLAMP_EN
        if (d < VAL_MIN) return VAL_MIN;
        if (d > VAL_MAX) return VAL_MAX;
`endif
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_tgt[i] = 0;
            m_cur[i] = 0;
        end
        m_pend  = 1'b0;
        m_sweep = 1'b0;
        m_idx   = 0;
        m_cnt   = 0;
        m_ovr   = 1'b0;
    endtask

    // Called on a falling edge: drive inputs, predict the next rising edge,
    // then wait for the following falling edge.
    task automatic cycle();
        req_t r;
        bit   hv, tick, was_sweep, was_pend, done;
        int   gap, mv;

        checks++;
        if (host_ready !== !m_pend) begin
            errors++;
            $display("FAIL host_ready cycle %0d: got %b want %b", cyc, host_ready, !m_pend);
        end

        hv = (req_q.size() > 0);
        if (hv) begin
            r          = req_q[0];
            host_addr  = CH_W'(r.addr);
            host_data  = VAL_W'(r.data);
            host_imm   = r.imm;
        end else begin
            host_addr  = CH_W'($urandom);
            host_data  = VAL_W'($urandom);
            host_imm   = 1'($urandom);
        end
        host_valid = hv;

        tick      = (m_cnt == TICK_DIV - 1);
        m_cnt     = tick ? 0 : m_cnt + 1;
        was_sweep = m_sweep;
        was_pend  = m_pend;
        done      = 1'b0;

        if (m_pend) begin
            m_tgt[m_pend_req.addr] = m_pend_req.data;
            if (m_pend_req.imm) begin
                m_cur[m_pend_req.addr] = m_pend_req.data;
                exp_q.push_back('{cyc + 1, m_pend_req.addr, m_pend_req.data});
            end
            m_pend = 1'b0;
        end else if (m_sweep) begin
            gap = m_tgt[m_idx] - m_cur[m_idx];
            if (gap != 0) begin
                if (gap > 0) mv = (gap < STEP) ? gap : STEP;
                else         mv = (-gap < STEP) ? gap : -STEP;
                m_cur[m_idx] += mv;
                exp_q.push_back('{cyc + 1, m_idx, m_cur[m_idx]});
            end
            if (m_idx == N_CH - 1) begin
                m_sweep = 1'b0;
                done    = 1'b1;
            end
            m_idx++;
        end

        if (tick) begin
            if (was_sweep) begin
                m_ovr = 1'b1;
            end else begin
                m_sweep = 1'b1;
                m_idx   = 0;
            end
        end

        if (hv && !was_pend) begin
            m_pend      = 1'b1;
            m_pend_req  = r;
            m_pend_req.data = host_value(r.data);
            void'(req_q.pop_front());
        end

        st_q.push_back('{cyc + 1, m_sweep, done, m_ovr});
        @(negedge clk);
    endtask

    // Starts on a falling edge (or time 0) and ends on a falling edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        mon_en = 1'b0;
        exp_q.delete();
        st_q.delete();
        req_q.delete();
        host_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || busy !== 1'b0 ||
            sweep_done !== 1'b0 || tick_overrun !== 1'b0 || host_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset outputs: got en=%b addr=%0d data=%0d busy=%b done=%b ovr=%b ready=%b, want all 0 and ready=1",
                     wr_en, wr_addr, wr_data, busy, sweep_done, tick_overrun, host_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic wait_sweep_idx(int idx);
        int n = 0;
        while (!(m_sweep && m_idx == idx && !m_pend && req_q.size() == 0) && n < 400) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL wait sweep idx %0d: got timeout after %0d cycles, want reached", idx, n);
        end
    endtask

    task automatic push_req(int a, int d, bit imm);
        req_t r;
        r.addr = a;
        r.data = d;
        r.imm  = imm;
        req_q.push_back(r);
    endtask

    // Monitor
    wr_exp_t mon_e;
    st_exp_t mon_s;
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (wr_en !== 1'b1 || wr_addr !== CH_W'(mon_e.addr) || wr_data !== VAL_W'(mon_e.data)) begin
                    errors++;
                    $display("FAIL write cycle %0d: got en=%b ch=%0d data=%0d, want ch=%0d data=%0d",
                             cyc, wr_en, wr_addr, wr_data, mon_e.addr, mon_e.data);
                end else begin
                    $display("write cycle %0d ch %0d data %0d ok", cyc, wr_addr, wr_data);
                end
            end else if (wr_en !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected write cycle %0d: got en=%b ch=%0d data=%0d, want no write",
                         cyc, wr_en, wr_addr, wr_data);
            end
            if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
                mon_s = st_q.pop_front();
                checks++;
                if (busy !== mon_s.busy || sweep_done !== mon_s.done || tick_overrun !== mon_s.ovr) begin
                    errors++;
                    $display("FAIL status cycle %0d: got busy=%b done=%b ovr=%b, want busy=%b done=%b ovr=%b",
                             cyc, busy, sweep_done, tick_overrun, mon_s.busy, mon_s.done, mon_s.ovr);
                end
            end
        end
    end

    initial begin
        host_valid = 1'b0;
        host_addr  = '0;
        host_data  = '0;
        host_imm   = 1'b0;
        do_reset();

        // Idle after reset: no writes before any request or tick.
        repeat (5) cycle();

        // Immediate write, ramp target, slow ramp on ch 10, over-range value.
        push_req(5, 1500, 1'b1);
        push_req(3, 20, 1'b0);
        push_req(10, 300, 1'b0);
        push_req(7, 2000, 1'b1);
        repeat (400) cycle();

        // Host write lands while the sweep is parked on ch 10.
        wait_sweep_idx(9);
        push_req(40, 999, 1'b1);
        repeat (80) cycle();

        // Back-to-back host requests.
        push_req(20, 111, 1'b1);
        push_req(21, 222, 1'b1);
        repeat (10) cycle();

        // Host flood stretches a sweep past the next tick.
        wait_sweep_idx(0);
        for (int i = 0; i < 60; i++) begin
            push_req(int'($urandom_range(63)), int'($urandom_range(2047)), 1'($urandom_range(1)));
        end
        repeat (300) cycle();
        checks++;
        if (tick_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun sticky: got %b want 1", tick_overrun);
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) begin
                push_req(int'($urandom_range(63)), int'($urandom_range(2047)), 1'($urandom_range(1)));
            end
            cycle();
        end

        // Reset in the middle of a sweep.
        wait_sweep_idx(30);
        do_reset();
        repeat (20) cycle();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(5) == 0) begin
                push_req(int'($urandom_range(63)), int'($urandom_range(2047)), 1'($urandom_range(1)));
            end
            cycle();
        end
        repeat (3) cycle();

        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL drain: got %0d writes outstanding, want at most 1", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_ramp_scheduler.md
Name: servo_ramp_scheduler

Overview:
- Owns per-channel target and current values for the 64-channel pulse bank.
- Serializes all writes into the channel register file through one write port, arbitrating between host (SPI) writes and a periodic ramp sweep.
- The ramp sweep slews each channel's current value toward its target by a fixed step.
- Sits between the SPI receiver and the channel register/organizer stage; its write port replaces the direct SPI path.

Parameters:
- N_CH, 64, number of channels
- CH_W, 6, channel index width
- VAL_W, 11, channel value width
- STEP, 8, maximum change per channel per sweep
- TICK_DIV, 50000, sweep period in clk cycles
- VAL_MIN, 0, clamp floor (CLAMP_EN only)
- VAL_MAX, 2047, clamp ceiling (CLAMP_EN only)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- host_valid  in  1  host write request
- host_ready  out  1  host request accepted when high with host_valid
- host_addr  in  CH_W  target channel
- host_data  in  VAL_W  value
- host_imm  in  1  1 = jump immediately; 0 = set ramp target only
- wr_en  out  1  register-file write strobe, one cycle per write
- wr_addr  out  CH_W  register-file write channel
- wr_data  out  VAL_W  register-file write value
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at sweep end
- tick_overrun  out  1  sticky; tick arrived while sweeping

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - target[] = 0, current[] = 0
  - wr_en / wr_addr / wr_data = 0
  - busy = 0, sweep_done = 0, tick_overrun = 0
  - pending slot empty, tick counter = 0, state IDLE
- Reset mid-sweep abandons the sweep with no partial write.
- Host interface:
  - One-entry pending slot; host_ready = !pend_valid (combinational).
  - Accept on host_valid && host_ready at edge N.
  - Pending entry is served at edge N+1 regardless of state; host has absolute priority over the sweep.
- Serving host_imm=1:
  - target[a] = current[a] = data.
  - wr_en=1, wr_addr=a, wr_data=data, visible after edge N+1.
- Serving host_imm=0:
  - target[a] = data only; no write.
  - Sweep converges current[a] toward the new target.
- Tick counter:
  - Counts 0..TICK_DIV-1 and asserts an internal tick at the wrap.
  - Free-running; never stalls.
- FSM states: IDLE, SWEEP.
- IDLE:
  - On tick: go to SWEEP, idx = 0, busy = 1.
- SWEEP, cycle with a pending host entry:
  - Serve the host entry; idx holds (stall).
- SWEEP, cycle without a pending host entry, processing channel idx:
  - If current != target: current moves toward target by min(STEP, |target-current|).
  - Emit wr_en with the new current value on the next cycle.
  - If current == target: no write.
  - idx increments.
- SWEEP exit:
  - After processing idx = N_CH-1: return to IDLE, busy = 0, sweep_done pulses one cycle.
  - Minimum sweep is N_CH cycles, plus one cycle per host entry served during the sweep.
- Tick while in SWEEP:
  - Set tick_overrun (cleared only by rst).
  - Tick is dropped; the sweep is not restarted.
- Arithmetic:
  - Difference computed at VAL_W+1 bits, signed; no wrap-around.
  - Step is never overshot; current stays within 0..2^VAL_W-1.
- Host target write to a channel being swept:
  - The write is serialized before that channel's sweep step, because the sweep stalls.
  - The sweep step then uses the new target.

Optional Feature:
- Macro: SERVO_RAMP_CLAMP_EN.
- Defined: host_data is clamped to [VAL_MIN, VAL_MAX] before being stored in target or current and before being written out.
- Undefined: host_data is used unmodified; VAL_MIN/VAL_MAX are ignored.

Decomposition:
- Shared package servo_pkg holds:
  - N_CH, CH_W, VAL_W constants
  - sched_state_t enum {IDLE, SWEEP}
  - write-port struct type {en, addr, data}
- One sub-module: sweep_tick_gen (TICK_DIV counter, rst, tick pulse out).
- Step/compare logic stays inline.

Test Plan:
- Reset: assert rst mid-sweep.
  - Expected: all outputs 0 and host_ready = 1 immediately (async).
  - Expected after release: no wr_en until the first host request or tick.
- Immediate write: host_imm=1, addr 5, data 1500.
  - Expected: exactly one wr_en, one cycle after accept, with addr 5 / data 1500.
  - Expected: following sweeps produce no writes to ch 5.
- Ramp convergence: STEP=8, TICK_DIV=100; target write ch 3 = 20 from 0.
  - Expected: ch 3 writes 8, 16, 20 on three successive sweeps, then none.
  - Expected: sweep_done pulses every 100 cycles.
- Host during sweep: host_imm write to ch 40 issued while idx = 10.
  - Expected: ch 40 write appears before the ch 10 step.
  - Expected: sweep length 65 cycles.
- Back-to-back host: host_valid held for 2 requests.
  - Expected: host_ready low one cycle between accepts.
  - Expected: both writes appear in order, addresses/data intact.
- Overrun: TICK_DIV=40.
  - Expected: tick_overrun set at cycle 80 (second tick, while the first sweep is still running) and stays set until rst.
  - Expected: the sweep completes all 64 channels without restart.
- Clamp: with SERVO_RAMP_CLAMP_EN, VAL_MAX=1800, imm write 2000.
  - Expected: wr_data = 1800.
